// File: rtl/ntt_bfly_stage.sv
// Pipelined NTT butterfly: Cooley-Tukey forward / Gentleman-Sande inverse, per-pair mode tag.
// Optional macro NTT_INV_HALVE_EN adds a stage scaling inverse outputs by 2^-1 mod Q.
module ntt_bfly_stage #(
  parameter int WIDTH   = 12,
  parameter int Q       = 3329,
  parameter int LOGN    = 8,
  parameter int STAGE   = 0,
  parameter int MUL_LAT = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_en_i,
  input  logic [2*WIDTH-1:0]   in_i,
  input  logic                 mode_i,
  output logic [LOGN-2:0]      rom_addr_o,
  output logic                 rom_inv_o,
  input  logic [WIDTH-1:0]     rom_data_i,
  output logic                 out_en_o,
  output logic [2*WIDTH-1:0]   out_o,
  output logic                 out_last_o
);

  localparam int PW = LOGN - 1;
  localparam logic [PW-1:0]      PCNT_MAX = '1;
  localparam logic [WIDTH:0]     QE = (WIDTH+1)'(Q);
  localparam logic [2*WIDTH-1:0] QW = (2*WIDTH)'(Q);

  function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= QE) s = s - QE;
    return WIDTH'(s);
  endfunction

  function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] s;
    s = {1'b0, x} - {1'b0, y};
    if (x < y) s = s + QE;
    return WIDTH'(s);
  endfunction

  // pair counter and frame mode
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          frame_mode_q, frame_mode_d;
  logic          cur_mode;

  assign cur_mode   = (pcnt_q == '0) ? mode_i : frame_mode_q;
  assign rom_addr_o = rst_ni ? (pcnt_q >> STAGE) : '0;
  assign rom_inv_o  = rst_ni ? cur_mode : mode_i;

  always_comb begin
    pcnt_d       = pcnt_q;
    frame_mode_d = frame_mode_q;
    if (in_en_i) begin
      pcnt_d = pcnt_q + PW'(1);
      if (pcnt_q == '0) frame_mode_d = mode_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pcnt_q       <= '0;
      frame_mode_q <= 1'b0;
    end else begin
      pcnt_q       <= pcnt_d;
      frame_mode_q <= frame_mode_d;
    end
  end

  // stage 1: forward registers a,b as-is; inverse registers a+b, a-b
  logic [WIDTH-1:0] a_in, b_in, s1_x_d, s1_y_d;
  logic [WIDTH-1:0] s1_x_q, s1_y_q;
  logic             s1_v_q, s1_m_q, s1_l_q;

  assign a_in   = in_i[2*WIDTH-1:WIDTH];
  assign b_in   = in_i[WIDTH-1:0];
  assign s1_x_d = cur_mode ? mod_add(a_in, b_in) : a_in;
  assign s1_y_d = cur_mode ? mod_sub(a_in, b_in) : b_in;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_v_q <= 1'b0;
      s1_m_q <= 1'b0;
      s1_l_q <= 1'b0;
      s1_x_q <= '0;
      s1_y_q <= '0;
    end else begin
      s1_v_q <= in_en_i;
      s1_m_q <= cur_mode;
      s1_l_q <= in_en_i && (pcnt_q == PCNT_MAX);
      s1_x_q <= s1_x_d;
      s1_y_q <= s1_y_d;
    end
  end

  // modular multiplier, MUL_LAT register stages; rom_data lands aligned with stage 1
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mul_res;
  logic [WIDTH-1:0]   mp_q [MUL_LAT];
  logic [WIDTH-1:0]   mx_q [MUL_LAT];
  logic               mv_q [MUL_LAT];
  logic               mm_q [MUL_LAT];
  logic               ml_q [MUL_LAT];

  assign prod    = (2*WIDTH)'(s1_y_q) * (2*WIDTH)'(rom_data_i);
  assign mul_res = WIDTH'(prod % QW);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        mp_q[i] <= '0;
        mx_q[i] <= '0;
        mv_q[i] <= 1'b0;
        mm_q[i] <= 1'b0;
        ml_q[i] <= 1'b0;
      end
    end else begin
      mp_q[0] <= mul_res;
      mx_q[0] <= s1_x_q;
      mv_q[0] <= s1_v_q;
      mm_q[0] <= s1_m_q;
      ml_q[0] <= s1_l_q;
      for (int i = 1; i < MUL_LAT; i++) begin
        mp_q[i] <= mp_q[i-1];
        mx_q[i] <= mx_q[i-1];
        mv_q[i] <= mv_q[i-1];
        mm_q[i] <= mm_q[i-1];
        ml_q[i] <= ml_q[i-1];
      end
    end
  end

  // result stage: forward does the add/sub here, inverse just registers
  logic [WIDTH-1:0]   x_m, p_m, r0_d, r1_d;
  logic               v_m, m_m, l_m;
  logic [2*WIDTH-1:0] r_d_q;
  logic               r_v_q, r_l_q;

  assign x_m  = mx_q[MUL_LAT-1];
  assign p_m  = mp_q[MUL_LAT-1];
  assign v_m  = mv_q[MUL_LAT-1];
  assign m_m  = mm_q[MUL_LAT-1];
  assign l_m  = ml_q[MUL_LAT-1];
  assign r0_d = m_m ? x_m : mod_add(x_m, p_m);
  assign r1_d = m_m ? p_m : mod_sub(x_m, p_m);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_v_q <= 1'b0;
      r_l_q <= 1'b0;
      r_d_q <= '0;
    end else begin
      r_v_q <= v_m;
      r_l_q <= v_m && l_m;
      if (v_m) r_d_q <= {r0_d, r1_d};
    end
  end

`ifdef NTT_INV_HALVE_EN
  function automatic logic [WIDTH-1:0] halve(input logic [WIDTH-1:0] x);
    logic [WIDTH:0] s;
    if (x[0]) s = ({1'b0, x} + QE) >> 1;
    else      s = {1'b0, x} >> 1;
    return WIDTH'(s);
  endfunction

  logic               r_m_q;
  logic [2*WIDTH-1:0] h_d_q;
  logic               h_v_q, h_l_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_m_q <= 1'b0;
    else         r_m_q <= m_m;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      h_v_q <= 1'b0;
      h_l_q <= 1'b0;
      h_d_q <= '0;
    end else begin
      h_v_q <= r_v_q;
      h_l_q <= r_l_q;
      if (r_v_q) begin
        h_d_q <= r_m_q ? {halve(r_d_q[2*WIDTH-1:WIDTH]), halve(r_d_q[WIDTH-1:0])} : r_d_q;
      end
    end
  end

  assign out_en_o   = h_v_q;
  assign out_last_o = h_l_q;
  assign out_o      = h_d_q;
`else
  assign out_en_o   = r_v_q;
  assign out_last_o = r_l_q;
  assign out_o      = r_d_q;
`endif

endmodule

// File: tb/tb_ntt_bfly_stage.sv
// Directed bench for ntt_bfly_stage (LOGN=4, STAGE=1); honours NTT_INV_HALVE_EN.
module tb_ntt_bfly_stage;
  localparam int W  = 12;
  localparam int Q  = 3329;
  localparam int NP = 8;
`ifdef NTT_INV_HALVE_EN
  localparam int L = 6;
`else
  localparam int L = 5;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_en;
  logic [2*W-1:0] in_d;
  logic          mode;
  logic [2:0]    rom_addr;
  logic          rom_inv;
  logic [W-1:0]  rom_data = '0;
  logic          out_en;
  logic [2*W-1:0] out_d;
  logic          out_last;

  ntt_bfly_stage #(.WIDTH(W), .Q(Q), .LOGN(4), .STAGE(1), .MUL_LAT(3)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_en_i(in_en), .in_i(in_d), .mode_i(mode),
    .rom_addr_o(rom_addr), .rom_inv_o(rom_inv), .rom_data_i(rom_data),
    .out_en_o(out_en), .out_o(out_d), .out_last_o(out_last)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int tw(input int addr, input logic inv);
    return inv ? (addr * 7 + 17) % Q : (addr * 13 + 17) % Q;
  endfunction

  // twiddle ROM with one cycle read latency
  always @(posedge clk) rom_data <= W'(tw(int'(rom_addr), rom_inv));

  typedef struct { int o0; int o1; int last; } exp_t;
  exp_t sb[$];
  int   tb_pcnt = 0;
  logic tb_fmode = 1'b0;
  int   last_o0 = 0;
  int   last_o1 = 0;
  logic mon_on = 1'b0;
  logic [7:0] hist = '0;

  always @(posedge clk) begin
    if (!rst_n) hist <= '0;
    else        hist <= {hist[6:0], in_en};
  end

  always @(negedge clk) begin
    if (mon_on) begin
      chk("out_en_timing", int'(out_en), int'(hist[L-1]));
      if (out_en) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", sb.size(), 1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out0", int'(out_d[2*W-1:W]), e.o0);
          chk("out1", int'(out_d[W-1:0]), e.o1);
          chk("out_last", int'(out_last), e.last);
          last_o0 = e.o0;
          last_o1 = e.o1;
        end
      end else begin
        chk("hold0", int'(out_d[2*W-1:W]), last_o0);
        chk("hold1", int'(out_d[W-1:0]), last_o1);
        chk("last_idle", int'(out_last), 0);
      end
    end
  end

  task automatic step(input logic en, input int a, input int b, input logic m, output int addr_seen);
    exp_t e;
    int   w, t;
    logic eff;
    in_en = en;
    in_d  = {a[W-1:0], b[W-1:0]};
    mode  = m;
    @(negedge clk);
    addr_seen = int'(rom_addr);
    if (en) begin
      eff = (tb_pcnt == 0) ? m : tb_fmode;
      chk("rom_addr", int'(rom_addr), tb_pcnt >> 1);
      chk("rom_inv", int'(rom_inv), int'(eff));
      w = tw(tb_pcnt >> 1, eff);
      if (!eff) begin
        t    = (w * b) % Q;
        e.o0 = (a + t) % Q;
        e.o1 = (a - t + Q) % Q;
      end else begin
        e.o0 = (a + b) % Q;
        e.o1 = (((a - b + Q) % Q) * w) % Q;
`ifdef NTT_INV_HALVE_EN
        e.o0 = (e.o0 * 1665) % Q;
        e.o1 = (e.o1 * 1665) % Q;
`endif
      end
      e.last = (tb_pcnt == NP - 1) ? 1 : 0;
      sb.push_back(e);
      if (tb_pcnt == 0) tb_fmode = m;
      tb_pcnt = (tb_pcnt + 1) % NP;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    int dummy;
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, dummy);
  endtask

  task automatic do_reset(input int n, input logic m);
    rst_n = 1'b0;
    in_en = 1'b1;
    mode  = m;
    in_d  = {12'd100, 12'd200};
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_rom_addr", int'(rom_addr), 0);
      chk("rst_rom_inv", int'(rom_inv), int'(m));
      @(posedge clk);
      #1;
      sb.delete();
      tb_pcnt  = 0;
      tb_fmode = 1'b0;
      last_o0  = 0;
      last_o1  = 0;
      mon_on   = 1'b1;
    end
    rst_n = 1'b1;
    in_en = 1'b0;
  endtask

  int addr;
  int seq[NP] = '{0, 0, 1, 1, 2, 2, 3, 3};
  int cnt;

  initial begin
    rst_n = 1'b0;
    in_en = 1'b0;
    mode  = 1'b0;
    in_d  = '0;
    @(posedge clk);
    #1;
    do_reset(2, 1'b0);

    // forward single pair, exact latency
    step(1'b1, 1, 2, 1'b0, addr);
    idle(L - 1);
    @(negedge clk);
    chk("fwd_en", int'(out_en), 1);
    chk("fwd_o0", int'(out_d[2*W-1:W]), 35);
    chk("fwd_o1", int'(out_d[W-1:0]), 3296);
    @(posedge clk);
    #1;
    idle(2);

    // inverse single pair
    do_reset(1, 1'b1);
    step(1'b1, 5, 7, 1'b1, addr);
    idle(L - 1);
    @(negedge clk);
    chk("inv_en", int'(out_en), 1);
`ifdef NTT_INV_HALVE_EN
    chk("inv_o0", int'(out_d[2*W-1:W]), 6);
    chk("inv_o1", int'(out_d[W-1:0]), 3312);
`else
    chk("inv_o0", int'(out_d[2*W-1:W]), 12);
    chk("inv_o1", int'(out_d[W-1:0]), 3295);
`endif
    @(posedge clk);
    #1;
    idle(2);

    // full frame back-to-back: address sequence and out_last
    do_reset(1, 1'b0);
    for (int i = 0; i < NP; i++) begin
      step(1'b1, 100 * i + 3, 3328 - 50 * i, 1'b0, addr);
      chk("addr_seq", addr, seq[i]);
    end

    // mode flips mid-frame (ignored), then an inverse frame with no gap
    for (int i = 0; i < NP; i++) step(1'b1, 400 + i * 311, 7 + i * 409, (i >= 3), addr);
    for (int i = 0; i < NP; i++) step(1'b1, 3000 - i * 211, 1000 + i * 17, (i != 5), addr);
    idle(L + 1);
    chk("drain_a", sb.size(), 0);

    // random bubbles over three frames
    cnt = 0;
    for (int it = 0; it < 400 && cnt < 3 * NP; it++) begin
      logic en;
      en = 1'($urandom_range(0, 1));
      step(en, int'($urandom_range(0, Q - 1)), int'($urandom_range(0, Q - 1)), 1'($urandom_range(0, 1)), addr);
      if (en) cnt++;
    end
    chk("rand_pairs", cnt, 3 * NP);
    idle(L + 1);
    chk("drain_b", sb.size(), 0);

    // reset with four pairs in flight
    for (int i = 0; i < 4; i++) step(1'b1, 11 + i, 22 + i, 1'b0, addr);
    do_reset(1, 1'b1);
    step(1'b1, 9, 4, 1'b0, addr);
    chk("post_rst_addr", addr, 0);
    idle(L + 2);
    chk("drain_c", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ntt_bfly_stage.md
NTT_BFLY_STAGE -- requirements
Module: ntt_bfly_stage

Interface
REQ-001 Parameter WIDTH, default 12: coefficient and twiddle width in bits.
REQ-002 Parameter Q, default 3329: modulus, with Q < 2^WIDTH.
REQ-003 Parameter LOGN, default 8: log2 of the polynomial length; a frame is 2^(LOGN-1) pairs.
REQ-004 Parameter STAGE, default 0: twiddle-address shift, in range 0..LOGN-2.
REQ-005 Parameter MUL_LAT, default 3: modular multiplier latency in cycles, at least 1.
REQ-006 clk  in  1: single clock; all state updates on the rising edge.
REQ-007 rst  in  1: reset, synchronous and active-low.
REQ-008 in_en  in  1: the input pair is valid this cycle.
REQ-009 in  in  2xWIDTH: input pair {a,b}, each in [0,Q).
REQ-010 mode  in  1: 0 = forward NTT (Cooley-Tukey), 1 = inverse NTT (Gentleman-Sande).
REQ-011 rom_addr  out  LOGN-1: twiddle ROM address.
REQ-012 rom_inv  out  1: twiddle table select, equal to the latched frame mode.
REQ-013 rom_data  in  WIDTH: twiddle w, valid one cycle after rom_addr is issued.
REQ-014 out_en  out  1: the output pair is valid.
REQ-015 out  out  2xWIDTH: output pair, each in [0,Q).
REQ-016 out_last  out  1: the output pair is the last pair of its frame.

Function
REQ-017 The pair counter pcnt (LOGN-1 bits) SHALL increment on each in_en and wrap from 2^(LOGN-1)-1 to 0; it SHALL hold when in_en=0, so bubbles are allowed anywhere.
REQ-018 rom_addr SHALL equal pcnt >> STAGE, combinationally, in the cycle in_en is high.
REQ-019 mode SHALL be latched into frame_mode when in_en=1 and pcnt=0.
REQ-020 For the rest of the frame, the pair SHALL use frame_mode and mode changes SHALL be ignored.
REQ-021 rom_inv SHALL equal mode when pcnt=0 and frame_mode otherwise.
REQ-022 Forward mode SHALL compute out0=(a+w*b) mod Q and out1=(a-w*b) mod Q.
REQ-023 The forward datapath SHALL be: input/twiddle register (1 cycle) -> multiplier (MUL_LAT cycles) -> add/sub register (1 cycle), with a delayed alongside the multiplier.
REQ-024 Inverse mode SHALL compute out0=(a+b) mod Q and out1=((a-b)*w) mod Q.
REQ-025 The inverse datapath SHALL be: add/sub register (1 cycle) -> multiplier (MUL_LAT cycles) -> output register (1 cycle), with w delayed to align with the multiplier.
REQ-026 Latency SHALL be L=MUL_LAT+2 cycles in both modes: out_en(t+L)=in_en(t), and the data and out_last move with it.
REQ-027 Pairs of different modes may be in flight at once; each pair SHALL carry its own mode tag down the pipeline.
REQ-028 out_last SHALL be high for the pair accepted at pcnt=2^(LOGN-1)-1.
REQ-029 Every add/sub SHALL reduce to [0,Q) with a single conditional correction: add Q after a subtract that underflows, subtract Q after an add that reaches Q or more.
REQ-030 Input values of Q or more give undefined output; no error flag is provided.
REQ-031 When out_en=0, out SHALL hold its last value.
REQ-032 Throughput SHALL be one pair per cycle with no back-pressure.

Reset
REQ-033 While rst=0 at a clock edge, the block SHALL clear pcnt, frame_mode, out_en, out_last, out and all pipeline valid/tag bits to 0.
REQ-034 Reset mid-frame SHALL drop all in-flight pairs; no out_en SHALL appear for them.
REQ-035 The first in_en after reset SHALL be treated as pcnt=0.
REQ-036 During reset, rom_addr SHALL be 0 and rom_inv SHALL follow mode.

Configuration
REQ-037 With macro NTT_INV_HALVE_EN defined, inverse-mode outputs SHALL each be multiplied by 2^-1 mod Q in an extra register stage.
REQ-038 Halving rule: if x is even, x/2; if x is odd, (x+Q)/2.
REQ-039 With NTT_INV_HALVE_EN defined, latency SHALL be MUL_LAT+3 in both modes; forward mode passes through the extra stage unchanged.
REQ-040 With NTT_INV_HALVE_EN undefined, there SHALL be no halving and latency SHALL be MUL_LAT+2.

Verification
REQ-041 Q=3329, mode=0, a=1, b=2, w=17 -> out={35,3296} exactly L cycles later.
REQ-042 Same parameters, mode=1, a=5, b=7, w=17 -> out={12,3295} without the macro, or {6,3312} with NTT_INV_HALVE_EN.
REQ-043 LOGN=4, STAGE=1, 8 back-to-back pairs -> rom_addr sequence 0,0,1,1,2,2,3,3, and out_last high only on the 8th output.
REQ-044 Mode toggled to 1 at pcnt=3 of a mode-0 frame -> the whole frame computes forward; a new frame started at once in mode 1 computes inverse with no gap between outputs.
REQ-045 Random in_en bubbles (50%) over 3 frames -> outputs match the reference model in order, with out_en exactly the input pattern delayed by L.
REQ-046 rst=0 for one cycle with 4 pairs in flight -> no out_en for those pairs, and the next pair is taken as pcnt=0 with rom_addr=0.
